// File: rtl/operand_bus_arbiter_if.sv
// rtl/operand_bus_arbiter_if.sv - operand bus request/grant bundle (ARB_URGENT_EN adds urgent)
interface operand_bus_arbiter_if;
    logic [15:0] req;
    logic        out_ready;
`ifdef ARB_URGENT_EN
    logic [15:0] urgent;
`endif
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        out_valid;
    logic [15:0] ack;
    logic        busy;

`ifdef ARB_URGENT_EN
    modport master (
        input  req,
        input  out_ready,
        input  urgent,
        output sel,
        output grant,
        output out_valid,
        output ack,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        output urgent,
        input  sel,
        input  grant,
        input  out_valid,
        input  ack,
        input  busy
    );
`else
    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output ack,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  ack,
        input  busy
    );
`endif
endinterface

// File: rtl/operand_bus_arbiter.sv
// rtl/operand_bus_arbiter.sv - 16-way round-robin operand bus arbiter with burst limit (ARB_URGENT_EN adds urgent)
module operand_bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_bus_arbiter_if.master bus
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [3:0]    owner;
    logic [15:0]   grant_q;
    logic          busy_q;
    logic [3:0]    ptr;
    logic [CW-1:0] beat_cnt;

    logic          owner_req;
    logic          out_valid;
    logic          accept;
    logic          release_now;
    logic          arb_point;
    logic [15:0]   cand;
    logic [3:0]    base;
    logic [3:0]    winner;
    logic          found;

    // Beat handshake: out_valid is suppressed while reset is held so an
    // aborted burst never produces an ack in the reset cycle.
    assign owner_req   = bus.req[owner];
    assign out_valid   = busy_q & owner_req & rst_n;
    assign accept      = out_valid & bus.out_ready;
    assign release_now = (state == GRANT) &
                         (~owner_req | (accept & (beat_cnt == LAST_BEAT)));
    assign arb_point   = (state == IDLE) | release_now;

    assign bus.sel       = owner;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid;
    assign bus.ack       = grant_q & {16{accept}};

    // Candidate set: urgent requesters take the whole search when any are present.
    always_comb begin
        cand = bus.req;
`ifdef ARB_URGENT_EN
        if ((bus.req & bus.urgent) != 16'h0000) begin
            cand = bus.req & bus.urgent;
        end
`endif
    end

    // Rotating search starting just after the last owner; at a release the
    // current owner is that last owner, so it lands at lowest priority.
    always_comb begin
        base   = (state == GRANT) ? owner : ptr;
        winner = 4'd0;
        found  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && cand[base + 4'(i + 1)]) begin
                found  = 1'b1;
                winner = base + 4'(i + 1);
            end
        end
    end

    // Arbitration FSM: grant/sel/busy only move at an arbitration point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 4'd0;
            grant_q  <= 16'h0000;
            busy_q   <= 1'b0;
            ptr      <= 4'hF;
            beat_cnt <= '0;
        end else if (arb_point) begin
            if (state == GRANT) begin
                ptr <= owner;
            end
            beat_cnt <= '0;
            if (found) begin
                state   <= GRANT;
                owner   <= winner;
                grant_q <= 16'h0001 << winner;
                busy_q  <= 1'b1;
            end else begin
                state   <= IDLE;
                grant_q <= 16'h0000;
                busy_q  <= 1'b0;
            end
        end else if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end

endmodule
